// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Producer-side hazard control for the 5-stage RV32I pipeline. It decides
//   when forwarded results actually exist and otherwise stalls, bubbles or
//   flushes the pipeline registers:
//     - data-memory wait (MEM access not ready): freeze PC/IF/ID/EXE/MEM regs
//       and bubble MEM/WB
//     - taken branch/jump resolved in EXE: flush IF/ID, bubble ID/EXE
//     - load-use: hold PC and IF/ID for one cycle, bubble ID/EXE
//   Priority is mem wait > branch > load-use. Control outputs are
//   combinational, so a stall acts in the cycle it is detected.
//
// Parameters
//   MEM_TIMEOUT  consecutive MEM_WAIT cycles before mem_timeout_err sets
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   IF_ID_read_reg1/2, IF_ID_use_*   source registers of the ID instruction
//   ID_EXE_mem_r, ID_EXE_written_reg load flag and rd of the EXE instruction
//   EXE_branch_taken                 taken branch/jal/jalr in EXE
//   EXE_MEM_mem_req, dmem_ready      data-memory access and completion
//   pc_write, *_write                pipeline register enables
//   IF_ID_flush, *_bubble            NOP insertion controls
//   mem_timeout_err                  sticky memory timeout flag
//   stall_cycles, flush_count        saturating performance counters
//
// Build option
//   HAZARD_PERF_EN  defined: counters implemented; undefined: both tied to 0.

module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_read_reg1,
    input  logic [4:0]       IF_ID_read_reg2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             ID_EXE_mem_r,
    input  logic [4:0]       ID_EXE_written_reg,
    input  logic             EXE_branch_taken,
    input  logic             EXE_MEM_mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EXE_write,
    output logic             ID_EXE_bubble,
    output logic             EXE_MEM_write,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, MEM_WAIT} state_e;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic mem_wait_cond;
    logic load_use;
    logic freeze;

    always_comb begin
        mem_wait_cond = EXE_MEM_mem_req & ~dmem_ready;
        load_use = ID_EXE_mem_r && (ID_EXE_written_reg != 5'd0) &&
                   ((IF_ID_use_rs1 && (ID_EXE_written_reg == IF_ID_read_reg1)) ||
                    (IF_ID_use_rs2 && (ID_EXE_written_reg == IF_ID_read_reg2)));
        // Once waiting, only dmem_ready releases the freeze.
        freeze = (state_q == RUN) ? mem_wait_cond : ~dmem_ready;

        state_d = state_q;
        case (state_q)
            RUN:      if (mem_wait_cond) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready)    state_d = RUN;
            default:  state_d = RUN;
        endcase

        // Wait counter runs only while we stay in MEM_WAIT; saturates at the
        // timeout so it cannot wrap back under it.
        wait_cnt_d = '0;
        if (state_q == MEM_WAIT && !dmem_ready)
            wait_cnt_d = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q
                                                   : wait_cnt_q + WAIT_W'(1);
        err_d = err_q | (wait_cnt_d == TIMEOUT_V);
    end

    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EXE_write  = 1'b1;
        ID_EXE_bubble = 1'b0;
        EXE_MEM_write = 1'b1;
        MEM_WB_bubble = 1'b0;
        if (freeze) begin
            // Branch/load-use are held and re-evaluated on release.
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EXE_write  = 1'b0;
            EXE_MEM_write = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (EXE_branch_taken) begin
            // The younger ID instruction is squashed, so load-use is moot.
            IF_ID_flush   = 1'b1;
            ID_EXE_bubble = 1'b1;
        end else if (load_use) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EXE_bubble = 1'b1;
        end
        if (!rst_n) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EXE_write  = 1'b0;
            ID_EXE_bubble = 1'b1;
            EXE_MEM_write = 1'b0;
            MEM_WB_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_write && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (IF_ID_flush && flush_count_q != '1)
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1, rs2, rd;
    logic use_rs1, use_rs2, mem_r, br, mem_req, rdy;
    logic pc_write, if_id_write, if_id_flush, id_exe_write, id_exe_bubble;
    logic exe_mem_write, mem_wb_bubble, err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_vec = 0;
    int n_err = 0;

    // {pc_w, ifid_w, ifid_flush, idexe_w, idexe_bubble, exemem_w, memwb_bubble}
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_RST = 7'b0010101;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0001110;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_read_reg1(rs1), .IF_ID_read_reg2(rs2),
        .IF_ID_use_rs1(use_rs1), .IF_ID_use_rs2(use_rs2),
        .ID_EXE_mem_r(mem_r), .ID_EXE_written_reg(rd),
        .EXE_branch_taken(br), .EXE_MEM_mem_req(mem_req), .dmem_ready(rdy),
        .pc_write(pc_write), .IF_ID_write(if_id_write), .IF_ID_flush(if_id_flush),
        .ID_EXE_write(id_exe_write), .ID_EXE_bubble(id_exe_bubble),
        .EXE_MEM_write(exe_mem_write), .MEM_WB_bubble(mem_wb_bubble),
        .mem_timeout_err(err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    wire [6:0] ctrl = {pc_write, if_id_write, if_id_flush, id_exe_write,
                       id_exe_bubble, exe_mem_write, mem_wb_bubble};

    function automatic logic [31:0] ec(input int v);
`ifdef HAZARD_PERF_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v - v);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; use_rs1 = 0; use_rs2 = 0;
        mem_r = 0; br = 0; mem_req = 0; rdy = 1;
    endtask

    // Inputs are already applied; check combinational controls mid-cycle,
    // then advance one clock and settle.
    task automatic cyc(input string tag, input logic [6:0] exp);
        #2;
        chk(tag, 32'(ctrl), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic set_lu(input logic via_rs2);
        mem_r = 1; rd = 5;
        rs1 = via_rs2 ? 5'd1 : 5'd5; use_rs1 = 1;
        rs2 = via_rs2 ? 5'd5 : 5'd2; use_rs2 = via_rs2;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #3;
        chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_flush", 32'(flush_count), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc("idle", C_DEF);

        // 1: load-use on rs1
        set_lu(0);
        cyc("lu_rs1", C_LU);
        chk("lu_stall1", 32'(stall_cycles), ec(1));
        idle();
        cyc("lu_after", C_DEF);

        // 2: no hazard on x0 or on an unused rs2; real hazard on rs2
        mem_r = 1; rd = 0; rs1 = 0; use_rs1 = 1;
        cyc("lu_x0", C_DEF);
        mem_r = 1; rd = 5; rs1 = 1; use_rs1 = 1; rs2 = 5; use_rs2 = 0;
        cyc("lu_rs2_unused", C_DEF);
        set_lu(1);
        cyc("lu_rs2", C_LU);
        chk("lu_stall2", 32'(stall_cycles), ec(2));
        idle();

        // 3: three-cycle memory wait then release
        mem_req = 1; rdy = 0;
        cyc("mw1", C_FRZ);
        cyc("mw2", C_FRZ);
        cyc("mw3", C_FRZ);
        rdy = 1;
        cyc("mw_rel", C_DEF);
        chk("mw_stall", 32'(stall_cycles), ec(5));
        cyc("mw_run", C_DEF);   // back in RUN: ready access does not freeze
        idle();

        // 4: branch beats load-use
        set_lu(0); br = 1;
        cyc("br_lu", C_BR);
        chk("br_flush", 32'(flush_count), ec(1));
        chk("br_stall", 32'(stall_cycles), ec(5));

        // held branch + load-use during a memory wait
        mem_req = 1; rdy = 0;
        cyc("held_frz", C_FRZ);
        rdy = 1;
        cyc("held_br", C_BR);
        mem_req = 0; br = 0;
        cyc("held_lu", C_LU);
        chk("held_stall", 32'(stall_cycles), ec(7));
        chk("held_flush", 32'(flush_count), ec(2));
        idle();

        // 5: timeout after the 4th MEM_WAIT cycle, sticky
        mem_req = 1; rdy = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc($sformatf("to_frz%0d", i), C_FRZ);
            chk($sformatf("to_err%0d", i), 32'(err), (i >= 5) ? 1 : 0);
        end
        chk("to_stall", 32'(stall_cycles), ec(13));
        #2; rst_n = 0; #1;
        chk("to_rst_ctrl", 32'(ctrl), 32'(C_RST));
        chk("to_rst_err", 32'(err), 0);
        chk("to_rst_stall", 32'(stall_cycles), 0);
        chk("to_rst_flush", 32'(flush_count), 0);
        @(posedge clk); #1;
        chk("to_rst_hold", 32'(ctrl), 32'(C_RST));
        chk("to_rst_err2", 32'(err), 0);
        idle();
        rst_n = 1;
        cyc("to_release", C_DEF);

        // 6: counter saturation at 15
        set_lu(0);
        for (int i = 1; i <= 20; i++) begin
            cyc("sat_lu", C_LU);
            if (i == 14) chk("sat_14", 32'(stall_cycles), ec(14));
            if (i == 15) chk("sat_15", 32'(stall_cycles), ec(15));
        end
        chk("sat_20", 32'(stall_cycles), ec(15));
        chk("sat_flush", 32'(flush_count), 0);
        idle();
        cyc("end_idle", C_DEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
